// File: rtl/act_skew_feeder.sv
// Activation skew feeder for a weight-stationary systolic array.
// Takes one activation vector per handshake and delays element r by r
// advances, so the array's left edge sees a diagonal wavefront. It also
// drives the shared PE enable and flushes the skew lines with zeros
// after the last vector of a tile.
module act_skew_feeder #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS*DATA_WIDTH-1:0] act_out,
    output logic [ROWS-1:0]            act_valid,
    output logic                       pe_enable,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // The drain counter only has to hold ROWS-1.
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt;
    logic             accept;
    logic             advance;
    logic             feed_vld;

    assign accept  = in_valid & in_ready;
    assign advance = pe_enable;
    // Outside DRAIN an advance only happens on an accept, so the fed
    // element is real; in DRAIN the lines are filled with zeros.
    assign feed_vld = (state != DRAIN);

    // State register, drain counter and registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic: enter DRAIN on the last vector, count down the flush.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (ROWS == 1) begin
                            // A single row has nothing to flush.
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = DRAIN;
                            cnt_nxt   = CNT_LOAD;
                        end
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            DRAIN: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and advance outputs; forced low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        pe_enable = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE, STREAM: begin
                    in_ready  = 1'b1;
                    // A stall inserts no bubble: nothing shifts.
                    pe_enable = in_valid;
                end
                DRAIN: begin
                    pe_enable = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One skew line per row: row r has r+1 stages, the top stage drives act_out.
    // The final real element sits on the top of the last row when done rises.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] feed_dat;

        assign feed_dat = feed_vld ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (r == 0) begin : g_tap
            logic [DATA_WIDTH-1:0] dat_sr;
            logic                  vld_sr;

            // Single-stage line for row 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_sr <= '0;
                    vld_sr <= 1'b0;
                end else if (advance) begin
                    dat_sr <= feed_dat;
                    vld_sr <= feed_vld;
                end
            end

            assign act_out[r*DATA_WIDTH +: DATA_WIDTH] = dat_sr;
            assign act_valid[r]                         = vld_sr;
        end else begin : g_line
            logic [(r+1)*DATA_WIDTH-1:0] dat_sr;
            logic [r:0]                  vld_sr;

            // Multi-stage line: new element enters at the bottom, oldest leaves at the top.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_sr <= '0;
                    vld_sr <= '0;
                end else if (advance) begin
                    dat_sr <= {dat_sr[r*DATA_WIDTH-1:0], feed_dat};
                    vld_sr <= {vld_sr[r-1:0], feed_vld};
                end
            end

            assign act_out[r*DATA_WIDTH +: DATA_WIDTH] = dat_sr[(r+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            assign act_valid[r]                         = vld_sr[r];
        end
    end

endmodule
